// File: rtl/main_memory_responder.sv
// Line-granular main-memory responder: one LOAD/STORE in flight, fixed access latency,
// synchronous single-port line RAM. Optional macro MAIN_MEMORY_BOUNDS_CHECK_EN flags out-of-range addresses.
module main_memory_responder #(
    parameter int LATENCY     = 10,
    parameter int DEPTH_LINES = 4096
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         request_valid_in,
    output logic         request_ready_out,
    input  logic         request_op_in,
    input  logic [22:0]  request_line_address_in,
    input  logic [99:0]  request_data_in,
    output logic         response_valid_out,
    input  logic         response_ready_in,
    output logic [99:0]  response_data_out,
    output logic         error_out,
    output logic [1:0]   debug_state_out
);

    // Handshake rule for both channels: a transfer happens on a rising clk_in edge
    // where valid and ready are both 1; valid never depends on ready in the same cycle.

    localparam int LINE_W = 100;
    localparam int ADDR_W = 23;
    localparam int AW     = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int CW     = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mem_op_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    mem_op_t             op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   data_q;
    logic                ready_q;
    logic                valid_q;
    logic [LINE_W-1:0]   rdata_q;
    logic                err_q;

    logic [LINE_W-1:0]   mem_q [DEPTH_LINES];

    logic                commit_d;
    logic                oob_d;
    logic                ram_we_d;
    logic [AW-1:0]       ram_idx_d;
    logic                addr_bits_unused;

    // The commit edge is the one on which the WAIT counter is already at zero.
    assign commit_d  = (state_q == WAIT) && (cnt_q == '0);
    assign ram_idx_d = addr_q[AW-1:0];
    assign addr_bits_unused = ^addr_q;

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
    assign oob_d = ({1'b0, addr_q} >= 24'(DEPTH_LINES));
`else
    assign oob_d = 1'b0;
`endif

    // A reset landing on the commit edge cancels the write as well.
    assign ram_we_d = commit_d && (op_q == OP_STORE) && !oob_d && !rst_in;

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk_in) begin
        if (ram_we_d) begin
            mem_q[ram_idx_d] <= data_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request_valid_in && ready_q) begin
                        op_q    <= mem_op_t'(request_op_in);
                        addr_q  <= request_line_address_in;
                        data_q  <= request_data_in;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (commit_d) begin
                        if ((op_q == OP_STORE) || oob_d) begin
                            rdata_q <= '0;
                        end else begin
                            rdata_q <= mem_q[ram_idx_d];
                        end
                        err_q   <= oob_d;
                        valid_q <= 1'b1;
                        state_q <= RESPOND;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESPOND: begin
                    // Ready is raised here so the IDLE cycle that follows can already accept.
                    if (response_ready_in) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign request_ready_out  = ready_q;
    assign response_valid_out = valid_q;
    assign response_data_out  = rdata_q;
    assign error_out          = err_q;
    assign debug_state_out    = state_q;

endmodule

// File: doc/main_memory_responder.md
# main_memory_responder

Line-granular main-memory responder sitting below the L2 cache. It accepts one LOAD (fill) or STORE (writeback) request per transaction on a valid/ready channel and holds it for a programmable access latency. It then returns a response on a second valid/ready channel. Lines are `cache_help::Line`: four 25-bit words, 100 bits total. Addresses are `cache_help::MemoryLineAddress` (23 bits). The backing store is a synchronous single-port RAM.

## Interface
Parameters:
- `LATENCY`, 10: cycles from request accept to `response_valid_out` rising; legal range ≥ 1.
- `DEPTH_LINES`, 4096: number of lines stored; must be a power of two, ≤ 2^23.

Ports:
- `clk_in` in 1: the single clock; all logic on its rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `request_valid_in` in 1: request present.
- `request_ready_out` out 1: responder can accept a request.
- `request_op_in` in 1: `MemoryOperation`; LOAD=0, STORE=1.
- `request_line_address_in` in 23: line address.
- `request_data_in` in 100: line to write; used on STORE only.
- `response_valid_out` out 1: response present.
- `response_ready_in` in 1: consumer takes the response.
- `response_data_out` out 100: line read on LOAD; all zeros on STORE.
- `error_out` out 1: out-of-range address flag, qualified by `response_valid_out`.

## Operation
- FSM states are IDLE, WAIT and RESPOND.
- **IDLE:**
  - `request_ready_out`=1.
  - A handshake (valid & ready) captures op, address and data into holding registers.
  - The down-counter loads `LATENCY-1`.
  - Next state is WAIT if `LATENCY`>1, else the commit is performed this edge +1 (see below).
- **WAIT:**
  - `request_ready_out`=0.
  - The counter decrements each cycle.
  - When the counter reaches 0, the commit happens on that edge:
    - LOAD: synchronous RAM read of line `addr mod DEPTH_LINES` into `response_data_out`.
    - STORE: RAM write of the held data; `response_data_out` ← 0.
  - Next state is RESPOND.
- **RESPOND:**
  - `response_valid_out`=1, with data and error held stable.
  - On `response_ready_in`=1 the next state is IDLE.
  - No new request is accepted in RESPOND, including the handshake cycle.
- Requests are strictly serialised: at most one in flight.
- Counter width is `$clog2(LATENCY+1)`; the counter never underflows.
- STORE followed by LOAD to the same line returns the stored data, because the commit precedes the response.
- The RAM contents are not affected by reset.

## Timing
- Reset values:
  - `request_ready_out`=0 during the reset cycle, 1 from the first cycle after `rst_in` falls.
  - `response_valid_out`=0, `response_data_out`=0, `error_out`=0.
  - State is IDLE and the counter is 0.
- Latency:
  - Request accepted at edge T gives `response_valid_out`=1 in the cycle after edge T+LATENCY.
  - The RAM commit happens at edge T+LATENCY.
- Minimum request-to-request spacing is LATENCY+2 cycles when `response_ready_in` is held high.
- Reset mid-operation (WAIT or RESPOND):
  - The in-flight request is dropped and the FSM returns to IDLE.
  - No response is produced.
  - A STORE whose commit edge had not yet occurred does not modify RAM.
- `request_*` inputs are ignored outside IDLE.
- Response backpressure holds RESPOND indefinitely with outputs unchanged.

## Configuration
- Macro: `MAIN_MEMORY_BOUNDS_CHECK_EN`.
- **Defined:**
  - An address ≥ `DEPTH_LINES` sets `error_out`=1 in RESPOND.
  - A LOAD to such an address returns all zeros.
  - A STORE to such an address is dropped, with no RAM write.
  - Timing is unchanged.
- **Undefined:**
  - `error_out` is tied to 0.
  - Addresses wrap modulo `DEPTH_LINES`, using the low `$clog2(DEPTH_LINES)` bits.

## Test plan
- Reset release:
  - Stimulus: hold `rst_in` 3 cycles.
  - Response: `request_ready_out` rises the cycle after release; response outputs stay 0.
- STORE then LOAD, `LATENCY`=10:
  - Stimulus: STORE addr 0x000005 with data {25'h1, 25'h2, 25'h3, 25'h4}, accepted at cycle 0; then LOAD addr 0x000005.
  - Response: STORE response valid at cycle 10 with data 0; LOAD response data {1,2,3,4} exactly 10 cycles after its accept.
- Backpressure:
  - Stimulus: hold `response_ready_in`=0 for 7 cycles during RESPOND.
  - Response: valid and data are stable throughout; `request_ready_out` stays 0; IDLE is re-entered the cycle after the ready pulse.
- `LATENCY`=1:
  - Stimulus: back-to-back LOADs to 0x0 and 0x1 with `response_ready_in`=1.
  - Response: each response valid one cycle after accept; spacing 3 cycles.
- Reset mid-WAIT:
  - Stimulus: STORE 0x0000AA with data 0x5 lanes; assert reset at cycle 4 of 10; then LOAD 0x0000AA.
  - Response: no response to the STORE; the LOAD returns the prior contents.
- With `MAIN_MEMORY_BOUNDS_CHECK_EN` and `DEPTH_LINES`=4096:
  - Stimulus: LOAD 0x001000.
  - Response: `error_out`=1, data 0.
  - Without the macro, the same LOAD returns line 0x000 with `error_out`=0.
